// File: rtl/dmem_dma_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and a burst DMA port.
// The CPU wins by default; a starvation counter forces a DMA beat after STARVE_LIMIT lost cycles.
//
//   state   | meaning
//   IDLE    | no burst; CPU owns memory; accepts dma_start with nonzero length
//   BURST   | burst in progress; beats use idle cycles or preempt a starved CPU
//   DONE    | one-cycle done pulse; CPU owns memory; dma_start ignored
module dmem_dma_arbiter #(
  parameter int DM_ADDRESS   = 9,
  parameter int DATA_W       = 32,
  parameter int LEN_W        = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [DM_ADDRESS-1:0] cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [2:0]            cpu_func3,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  dma_start,
  input  logic                  dma_dir,
  input  logic [DM_ADDRESS-1:0] dma_base,
  input  logic [LEN_W-1:0]      dma_len,
  input  logic [DATA_W-1:0]     dma_wdata,
  output logic                  dma_wready,
  output logic [DATA_W-1:0]     dma_rdata,
  output logic                  dma_rvalid,
  output logic                  dma_busy,
  output logic                  dma_done,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_func3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]            state;
  logic                  dir_q;
  logic [DM_ADDRESS-1:0] base_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      idx;
  logic [SC_W-1:0]       starve_cnt;

  logic                  cpu_req;
  logic                  in_burst;
  logic                  starved;
  logic                  beat;
  logic                  last_beat;
  logic [DM_ADDRESS-1:0] beat_addr;

  assign cpu_req   = cpu_rd | cpu_wr;
  assign in_burst  = (state == S_BURST);
  assign starved   = (starve_cnt == SC_W'(STARVE_LIMIT));
  assign beat      = in_burst && (!cpu_req || starved);
  assign last_beat = (idx == len_q - LEN_W'(1));
  // Address arithmetic truncates to DM_ADDRESS, so bursts wrap around the memory.
  assign beat_addr = base_q + DM_ADDRESS'({idx, 2'b00});

  assign dma_busy  = in_burst;
  assign dma_done  = (state == S_DONE);
  assign cpu_rdata = mem_rdata;
  assign dma_rdata = mem_rdata;

  always_comb begin
    mem_rd     = cpu_rd;
    mem_wr     = cpu_wr;
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    mem_func3  = cpu_func3;
    cpu_stall  = 1'b0;
    dma_wready = 1'b0;
    dma_rvalid = 1'b0;
    if (beat) begin
      mem_rd     = ~dir_q;
      mem_wr     = dir_q;
      mem_addr   = beat_addr;
      mem_wdata  = dma_wdata;
      mem_func3  = 3'b010;
      cpu_stall  = cpu_req;
      dma_wready = dir_q;
      dma_rvalid = ~dir_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      dir_q      <= 1'b0;
      base_q     <= '0;
      len_q      <= '0;
      idx        <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dma_start && (dma_len != '0)) begin
            dir_q      <= dma_dir;
            base_q     <= {dma_base[DM_ADDRESS-1:2], 2'b00};
            len_q      <= dma_len;
            idx        <= '0;
            starve_cnt <= '0;
            state      <= S_BURST;
          end
        end
        S_BURST: begin
          if (beat) begin
            idx        <= idx + LEN_W'(1);
            starve_cnt <= '0;
            if (last_beat) state <= S_DONE;
          end else if (cpu_req) begin
            starve_cnt <= starve_cnt + SC_W'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_dma_arbiter.sv
// Directed and random stimulus for dmem_dma_arbiter, checked against a queue-based
// burst model and a shadow of the data memory.
module tb_dmem_dma_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [8:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [2:0]  cpu_func3 = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dma_start = 1'b0, dma_dir = 1'b0;
  logic [8:0]  dma_base = '0;
  logic [4:0]  dma_len = '0;
  logic [31:0] dma_wdata = '0;
  logic        dma_wready;
  logic [31:0] dma_rdata;
  logic        dma_rvalid, dma_busy, dma_done;
  logic        mem_rd, mem_wr;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_func3;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:127];
  logic [31:0] exp_mem [0:127];

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[8:2]];
  always @(posedge clk) if (mem_wr) mem[mem_addr[8:2]] <= mem_wdata;

  dmem_dma_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .LEN_W(5), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_func3(cpu_func3), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_start(dma_start), .dma_dir(dma_dir), .dma_base(dma_base), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_wready(dma_wready), .dma_rdata(dma_rdata),
    .dma_rvalid(dma_rvalid), .dma_busy(dma_busy), .dma_done(dma_done),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_func3(mem_func3), .mem_rdata(mem_rdata)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: remaining beat addresses of the active burst, plus a pending done flag.
  int pend[$];
  bit m_dir = 1'b0;
  bit m_done = 1'b0;
  int starve = 0;

  int cyc_n = 0;
  int start_at = 0;
  int done_at = -1;
  int n_beats = 0, n_done = 0, n_stall = 0;
  int obs_addr[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    n_beats = 0; n_done = 0; n_stall = 0; done_at = -1;
    obs_addr.delete();
    start_at = cyc_n;
  endtask

  task automatic cyc(input bit rd, input bit wr, input logic [8:0] a, input logic [31:0] wd,
                     input logic [2:0] f3, input bit st, input bit dir,
                     input logic [8:0] base, input logic [4:0] len);
    bit busy_e, done_e, req, beat_e;
    int ba;
    @(negedge clk);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = wd; cpu_func3 = f3;
    dma_start = st; dma_dir = dir; dma_base = base; dma_len = len; dma_wdata = $urandom;
    #1;
    busy_e = (pend.size() != 0);
    done_e = m_done;
    req    = rd | wr;
    beat_e = busy_e && (!req || starve == LIMIT);
    ba     = beat_e ? pend[0] : 0;
    chk("dma_busy", 32'(dma_busy), 32'(busy_e));
    chk("dma_done", 32'(dma_done), 32'(done_e));
    chk("cpu_stall", 32'(cpu_stall), 32'(beat_e && req));
    if (beat_e) begin
      chk("beat_addr", 32'(mem_addr), 32'(ba));
      chk("beat_rd", 32'(mem_rd), 32'(!m_dir));
      chk("beat_wr", 32'(mem_wr), 32'(m_dir));
      chk("beat_func3", 32'(mem_func3), 32'h2);
      chk("dma_wready", 32'(dma_wready), 32'(m_dir));
      chk("dma_rvalid", 32'(dma_rvalid), 32'(!m_dir));
      if (m_dir) chk("beat_wdata", mem_wdata, dma_wdata);
      else       chk("dma_rdata", dma_rdata, exp_mem[ba >> 2]);
    end else begin
      chk("cpu_addr_pass", 32'(mem_addr), 32'(a));
      chk("cpu_rd_pass", 32'(mem_rd), 32'(rd));
      chk("cpu_wr_pass", 32'(mem_wr), 32'(wr));
      chk("idle_wready", 32'(dma_wready), 32'h0);
      chk("idle_rvalid", 32'(dma_rvalid), 32'h0);
      if (req) chk("cpu_func3_pass", 32'(mem_func3), 32'(f3));
      if (wr)  chk("cpu_wdata_pass", mem_wdata, wd);
      if (rd)  chk("cpu_rdata", cpu_rdata, exp_mem[a[8:2]]);
    end
    if (dma_wready || dma_rvalid) begin
      n_beats++;
      obs_addr.push_back(int'(mem_addr));
    end
    if (dma_done) begin
      n_done++;
      done_at = cyc_n;
    end
    if (cpu_stall) n_stall++;
    cyc_n++;
    // Advance the model to what the coming clock edge must produce.
    if (beat_e) begin
      void'(pend.pop_front());
      if (m_dir) exp_mem[ba >> 2] = dma_wdata;
      starve = 0;
    end else begin
      if (wr) exp_mem[a[8:2]] = wd;
      if (busy_e && req) starve++;
    end
    m_done = beat_e && (pend.size() == 0);
    if (!busy_e && !done_e && st && len != 0) begin
      for (int k = 0; k < int'(len); k++) pend.push_back(((int'(base) & 'h1FC) + 4 * k) & 'h1FF);
      m_dir = dir;
      starve = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 9'h040; cpu_func3 = 3'b010; dma_start = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_busy", 32'(dma_busy), 32'h0);
    chk("rst_done", 32'(dma_done), 32'h0);
    chk("rst_stall", 32'(cpu_stall), 32'h0);
    chk("rst_wready", 32'(dma_wready), 32'h0);
    chk("rst_rvalid", 32'(dma_rvalid), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h040);
    chk("rst_mem_rd", 32'(mem_rd), 32'h1);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    pend.delete(); m_done = 1'b0; starve = 0;
    @(negedge clk);
    cpu_rd = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    // Reset state while reset is held from time zero.
    @(negedge clk);
    #1;
    chk("init_busy", 32'(dma_busy), 32'h0);
    chk("init_done", 32'(dma_done), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Fill memory through the CPU port so model and memory agree.
    for (int i = 0; i < 128; i++) cyc(0, 1, 9'(4 * i), $urandom, 3'b010, 0, 0, '0, '0);

    // Write burst, CPU idle.
    clr_stats();
    cyc(0, 0, '0, '0, '0, 1, 1, 9'h010, 5'd4);
    idle(6);
    chk("wr_beats", 32'(n_beats), 32'd4);
    chk("wr_done_lat", 32'(done_at - start_at), 32'd5);
    chk("wr_n_done", 32'(n_done), 32'd1);
    if (obs_addr.size() == 4) begin
      chk("wr_a0", 32'(obs_addr[0]), 32'h010);
      chk("wr_a3", 32'(obs_addr[3]), 32'h01C);
    end else chk("wr_addr_count", 32'(obs_addr.size()), 32'd4);

    // Read burst under continuous CPU loads.
    clr_stats();
    cyc(1, 0, 9'h100, '0, 3'b010, 1, 0, 9'h040, 5'd2);
    for (int i = 0; i < 13; i++) cyc(1, 0, 9'(4 * i), '0, 3'b010, 0, 0, '0, '0);
    chk("starve_stalls", 32'(n_stall), 32'd2);
    chk("starve_beats", 32'(n_beats), 32'd2);
    chk("starve_done_lat", 32'(done_at - start_at), 32'd11);

    // Address wrap and base alignment.
    clr_stats();
    cyc(0, 0, '0, '0, '0, 1, 0, 9'h1F8, 5'd4);
    idle(6);
    if (obs_addr.size() == 4) begin
      chk("wrap_a1", 32'(obs_addr[1]), 32'h1FC);
      chk("wrap_a2", 32'(obs_addr[2]), 32'h000);
      chk("wrap_a3", 32'(obs_addr[3]), 32'h004);
    end else chk("wrap_count", 32'(obs_addr.size()), 32'd4);
    clr_stats();
    cyc(0, 0, '0, '0, '0, 1, 1, 9'h013, 5'd2);
    idle(4);
    if (obs_addr.size() == 2) chk("align_a0", 32'(obs_addr[0]), 32'h010);
    else chk("align_count", 32'(obs_addr.size()), 32'd2);

    // CPU stores every other cycle during a write burst; then read them back.
    clr_stats();
    cyc(0, 0, '0, '0, '0, 1, 1, 9'h080, 5'd3);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) cyc(0, 1, 9'(9'h0C0 + 4 * i), $urandom, 3'b010, 0, 0, '0, '0);
      else idle(1);
    end
    chk("gap_stalls", 32'(n_stall), 32'd0);
    chk("gap_beats", 32'(n_beats), 32'd3);
    for (int i = 0; i < 8; i += 2) cyc(1, 0, 9'(9'h0C0 + 4 * i), '0, 3'b010, 0, 0, '0, '0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 9'(9'h080 + 4 * i), '0, 3'b010, 0, 0, '0, '0);

    // Starts while busy and during the done cycle are ignored; len=0 is ignored.
    clr_stats();
    cyc(0, 0, '0, '0, '0, 1, 0, 9'h020, 5'd4);
    cyc(0, 0, '0, '0, '0, 1, 1, 9'h100, 5'd5);
    idle(3);
    cyc(0, 0, '0, '0, '0, 1, 1, 9'h140, 5'd3);
    idle(5);
    chk("ign_beats", 32'(n_beats), 32'd4);
    chk("ign_n_done", 32'(n_done), 32'd1);
    clr_stats();
    cyc(0, 0, '0, '0, '0, 1, 1, 9'h020, 5'd0);
    idle(4);
    chk("len0_beats", 32'(n_beats), 32'd0);
    chk("len0_done", 32'(n_done), 32'd0);

    // Reset mid-burst, then a fresh burst starts at index 0.
    clr_stats();
    cyc(0, 0, '0, '0, '0, 1, 1, 9'h180, 5'd8);
    idle(2);
    do_reset();
    idle(3);
    chk("rst_beats", 32'(n_beats), 32'd2);
    chk("rst_no_done", 32'(n_done), 32'd0);
    clr_stats();
    cyc(0, 0, '0, '0, '0, 1, 0, 9'h100, 5'd2);
    idle(4);
    if (obs_addr.size() == 2) chk("post_rst_a0", 32'(obs_addr[0]), 32'h100);
    else chk("post_rst_count", 32'(obs_addr.size()), 32'd2);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 3);
      cyc(r == 1, r == 2, 9'({$urandom_range(0, 127), 2'b00}), $urandom, 3'($urandom_range(0, 7)),
          $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)),
          5'($urandom_range(0, 6)));
    end
    idle(40);
    for (int i = 0; i < 128; i++) cyc(1, 0, 9'(4 * i), '0, 3'b010, 0, 0, '0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
